// File: rtl/rx_pkt_buffer.sv
// rtl/rx_pkt_buffer.sv - receive packet buffer: packs MAC bytes into words, keeps good frames, streams them to the core
module rx_pkt_buffer #(
  parameter int DATA_WIDTH     = 64,
  parameter int CTRL_WIDTH     = DATA_WIDTH / 8,
  parameter int BUF_ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            gmac_rx_data,
  input  logic                  gmac_rx_dvld,
  input  logic                  gmac_rx_goodframe,
  input  logic                  gmac_rx_badframe,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic                  rx_queue_en,
  output logic                  rx_pkt_good,
  output logic                  rx_pkt_bad,
  output logic                  rx_pkt_dropped,
  output logic [11:0]           rx_pkt_byte_cnt
);
  localparam int IDX_W   = $clog2(CTRL_WIDTH);
  localparam int PTR_W   = BUF_ADDR_WIDTH + 1;
  localparam int ENTRY_W = DATA_WIDTH + CTRL_WIDTH;
  localparam logic [PTR_W-1:0] DEPTH = {1'b1, {BUF_ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {WR_IDLE, WR_PKT, WR_STATUS, WR_DROP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_PKT} rd_state_t;

  logic [ENTRY_W-1:0] mem [2**BUF_ADDR_WIDTH];

  wr_state_t wr_state, wr_state_nxt;
  rd_state_t rd_state, rd_state_nxt;

  logic [PTR_W-1:0]      wr_ptr, commit_ptr, rd_ptr, pkts_waiting;
  logic                  dvld_d;
  logic [DATA_WIDTH-1:0] acc;
  logic [IDX_W-1:0]      byte_idx;
  logic                  word_full;
  logic [11:0]           byte_cnt;

  logic                  dvld_rise, dvld_fall, buf_full, start_ok;
  logic                  frame_start, take_byte, do_write, wr_last, rewind, commit;
  logic                  good_nxt, bad_nxt, drop_nxt;
  logic [DATA_WIDTH-1:0] byte_placed;
  logic [IDX_W-1:0]      last_bit;
  logic [CTRL_WIDTH-1:0] wr_ctrl;
  logic [ENTRY_W-1:0]    rd_entry;
  logic                  rd_go, rd_eop;

  assign dvld_rise   = gmac_rx_dvld & ~dvld_d;
  assign dvld_fall   = ~gmac_rx_dvld & dvld_d;
  assign buf_full    = (wr_ptr - rd_ptr) == DEPTH;
  // A new frame starts from commit_ptr, so a pending rewind never blocks it.
  assign start_ok    = rx_queue_en && ((commit_ptr - rd_ptr) != DEPTH);
  assign byte_placed = {gmac_rx_data, {(DATA_WIDTH-8){1'b0}}} >> {byte_idx, 3'b000};
  assign last_bit    = IDX_W'(0) - byte_idx;
  assign wr_ctrl     = wr_last ? (CTRL_WIDTH'(1) << last_bit) : '0;
  assign take_byte   = (wr_state == WR_PKT) && gmac_rx_dvld && (wr_state_nxt == WR_PKT);

  always_comb begin
    wr_state_nxt = wr_state;
    frame_start  = 1'b0;
    do_write     = 1'b0;
    wr_last      = 1'b0;
    rewind       = 1'b0;
    commit       = 1'b0;
    good_nxt     = 1'b0;
    bad_nxt      = 1'b0;
    drop_nxt     = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (dvld_rise) begin
          frame_start  = start_ok;
          wr_state_nxt = start_ok ? WR_PKT : WR_DROP;
        end
      end
      WR_PKT: begin
        // The held word goes out when another byte arrives or the frame ends.
        if (dvld_fall || (gmac_rx_dvld && word_full)) begin
          if (buf_full) begin
            wr_state_nxt = WR_DROP;
          end else begin
            do_write = 1'b1;
            wr_last  = dvld_fall;
            if (dvld_fall) wr_state_nxt = WR_STATUS;
          end
        end
      end
      WR_STATUS: begin
        if (gmac_rx_goodframe) begin
          commit       = 1'b1;
          good_nxt     = 1'b1;
          wr_state_nxt = WR_IDLE;
        end else if (gmac_rx_badframe) begin
          rewind       = 1'b1;
          bad_nxt      = 1'b1;
          wr_state_nxt = WR_IDLE;
        end else if (dvld_rise) begin
          rewind       = 1'b1;
          bad_nxt      = 1'b1;
          frame_start  = start_ok;
          wr_state_nxt = start_ok ? WR_PKT : WR_DROP;
        end
      end
      WR_DROP: begin
        rewind = 1'b1;
        if (!gmac_rx_dvld && (gmac_rx_goodframe || gmac_rx_badframe)) begin
          drop_nxt     = 1'b1;
          wr_state_nxt = WR_IDLE;
        end
      end
      default: wr_state_nxt = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_state        <= WR_IDLE;
      dvld_d          <= 1'b1;
      acc             <= '0;
      byte_idx        <= '0;
      word_full       <= 1'b0;
      byte_cnt        <= '0;
      wr_ptr          <= '0;
      commit_ptr      <= '0;
      rx_pkt_good     <= 1'b0;
      rx_pkt_bad      <= 1'b0;
      rx_pkt_dropped  <= 1'b0;
      rx_pkt_byte_cnt <= '0;
    end else begin
      wr_state       <= wr_state_nxt;
      dvld_d         <= gmac_rx_dvld;
      rx_pkt_good    <= good_nxt;
      rx_pkt_bad     <= bad_nxt;
      rx_pkt_dropped <= drop_nxt;
      if (frame_start) begin
        acc       <= {gmac_rx_data, {(DATA_WIDTH-8){1'b0}}};
        byte_idx  <= IDX_W'(1);
        word_full <= 1'b0;
        byte_cnt  <= 12'd1;
      end else if (take_byte) begin
        acc       <= (word_full ? '0 : acc) | byte_placed;
        byte_idx  <= byte_idx + IDX_W'(1);
        word_full <= (byte_idx == {IDX_W{1'b1}});
        if (byte_cnt != 12'hFFF) byte_cnt <= byte_cnt + 12'd1;
      end
      if (rewind) begin
        wr_ptr <= commit_ptr;
      end else if (do_write) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (commit) begin
        commit_ptr      <= wr_ptr;
        rx_pkt_byte_cnt <= byte_cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr[BUF_ADDR_WIDTH-1:0]] <= {acc, wr_ctrl};
  end

  assign rd_entry = mem[rd_ptr[BUF_ADDR_WIDTH-1:0]];
  // Reading starts in the same cycle pkts_waiting turns nonzero to meet the two-cycle latency.
  assign rd_go  = ((rd_state == RD_PKT) || (pkts_waiting != '0)) && out_rdy && (rd_ptr != commit_ptr);
  assign rd_eop = rd_go && (rd_entry[CTRL_WIDTH-1:0] != '0);

  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      RD_IDLE: if (pkts_waiting != '0) rd_state_nxt = rd_eop ? RD_IDLE : RD_PKT;
      RD_PKT:  if (rd_eop) rd_state_nxt = RD_IDLE;
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_state     <= RD_IDLE;
      rd_ptr       <= '0;
      pkts_waiting <= '0;
      out_wr       <= 1'b0;
      out_data     <= '0;
      out_ctrl     <= '0;
    end else begin
      rd_state <= rd_state_nxt;
      out_wr   <= rd_go;
      if (rd_go) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        out_data <= rd_entry[ENTRY_W-1 -: DATA_WIDTH];
        out_ctrl <= rd_entry[CTRL_WIDTH-1:0];
      end
      case ({commit, rd_eop})
        2'b10:   pkts_waiting <= pkts_waiting + PTR_W'(1);
        2'b01:   pkts_waiting <= pkts_waiting - PTR_W'(1);
        default: pkts_waiting <= pkts_waiting;
      endcase
    end
  end
endmodule

// File: tb/tb_rx_pkt_buffer.sv
// tb/tb_rx_pkt_buffer.sv - randomized self-checking bench for rx_pkt_buffer against a frame-level model
module tb_rx_pkt_buffer;
  localparam int DEPTH = 16;
  localparam logic [2:0] P_GOOD = 3'b100, P_BAD = 3'b010, P_DROP = 3'b001;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  gmac_rx_data = '0;
  logic        gmac_rx_dvld = 1'b0, gmac_rx_goodframe = 1'b0, gmac_rx_badframe = 1'b0;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy = 1'b0, rx_queue_en = 1'b1;
  logic        rx_pkt_good, rx_pkt_bad, rx_pkt_dropped;
  logic [11:0] rx_pkt_byte_cnt;

  rx_pkt_buffer #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .BUF_ADDR_WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .gmac_rx_data(gmac_rx_data), .gmac_rx_dvld(gmac_rx_dvld),
    .gmac_rx_goodframe(gmac_rx_goodframe), .gmac_rx_badframe(gmac_rx_badframe),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .rx_queue_en(rx_queue_en), .rx_pkt_good(rx_pkt_good), .rx_pkt_bad(rx_pkt_bad),
    .rx_pkt_dropped(rx_pkt_dropped), .rx_pkt_byte_cnt(rx_pkt_byte_cnt));

  always #5 clk = ~clk;

  typedef struct packed { logic [63:0] data; logic [7:0] ctrl; } word_t;
  typedef struct packed { logic [2:0] pulses; logic [11:0] cnt; } evt_t;

  word_t      exp_q[$];
  evt_t       evt_q[$];
  word_t      wr_log[$];
  int         wr_cyc[$];
  logic [7:0] fb[$];
  int n_checks = 0, n_pass = 0;
  int cyc = 0, drive_cyc = 0, pulse_cyc = 0;
  int n_good = 0, n_bad = 0, n_drop = 0;
  bit rdy_prev = 1'b0, rdy_rand = 1'b0;
  word_t cur_w;
  evt_t  cur_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame-level model: wire bytes packed first-byte-high, EOP one-hot on the last byte.
  function automatic void push_words();
    int n = fb.size();
    int nw = (n + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      word_t x;
      x = '0;
      for (int k = 0; k < 8; k++)
        if (w * 8 + k < n) x.data[63 - 8 * k -: 8] = fb[w * 8 + k];
      if (w == nw - 1) x.ctrl = 8'h80 >> ((n - 1) % 8);
      exp_q.push_back(x);
    end
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      check("reset_outputs", {out_data, out_ctrl, out_wr, rx_pkt_good, rx_pkt_bad,
                              rx_pkt_dropped, rx_pkt_byte_cnt}, 0);
    end else begin
      if (!rdy_prev) check("wr_after_rdy_low", out_wr, 0);
      if (out_wr) begin
        wr_log.push_back({out_data, out_ctrl});
        wr_cyc.push_back(cyc);
        if (exp_q.size() == 0) check("unexpected_word", {out_data, out_ctrl}, 128'h1_0000_0000_0000_0000_00);
        else begin
          cur_w = exp_q.pop_front();
          check("word", {out_data, out_ctrl}, cur_w);
        end
      end
      if (rx_pkt_good || rx_pkt_bad || rx_pkt_dropped) begin
        n_good += int'(rx_pkt_good);
        n_bad  += int'(rx_pkt_bad);
        n_drop += int'(rx_pkt_dropped);
        pulse_cyc = cyc;
        if (evt_q.size() == 0) check("unexpected_status", {rx_pkt_good, rx_pkt_bad, rx_pkt_dropped}, 0);
        else begin
          cur_e = evt_q.pop_front();
          check("status_kind", {rx_pkt_good, rx_pkt_bad, rx_pkt_dropped}, cur_e.pulses);
          if (cur_e.pulses == P_GOOD) check("byte_cnt", rx_pkt_byte_cnt, cur_e.cnt);
        end
      end
    end
    rdy_prev = out_rdy;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_rand) out_rdy = 1'($urandom_range(0, 1));
  end

  // status: 0 goodframe, 1 badframe, 2 none (next frame's dvld rise ends it)
  task automatic send_frame(input int len, input int status, input bit seq);
    int words;
    bit en, fits;
    words = (len + 7) / 8;
    en    = rx_queue_en;
    fits  = (words + exp_q.size()) <= DEPTH;
    fb.delete();
    for (int i = 0; i < len; i++) begin
      fb.push_back(seq ? 8'(i) : 8'($urandom));
      gmac_rx_data = fb[i];
      gmac_rx_dvld = 1'b1;
      tick();
    end
    gmac_rx_dvld = 1'b0;
    gmac_rx_data = '0;
    if (status == 2) begin
      evt_q.push_back({P_BAD, 12'd0});
      return;
    end
    repeat ($urandom_range(1, 2)) tick();
    if (!en || !fits) evt_q.push_back({P_DROP, 12'd0});
    else if (status == 0) begin
      evt_q.push_back({P_GOOD, 12'(len > 4095 ? 4095 : len)});
      push_words();
    end else evt_q.push_back({P_BAD, 12'd0});
    if (status == 0) gmac_rx_goodframe = 1'b1;
    else gmac_rx_badframe = 1'b1;
    drive_cyc = cyc;
    tick();
    gmac_rx_goodframe = 1'b0;
    gmac_rx_badframe  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || evt_q.size() != 0) && n < 2000) begin
      tick();
      n++;
    end
    repeat (4) tick();
    check(name, {32'(exp_q.size()), 32'(evt_q.size())}, 0);
  endtask

  task automatic wait_room(input int words);
    int n = 0;
    while (exp_q.size() + words > DEPTH && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) check("room_timeout", exp_q.size(), DEPTH - words);
  endtask

  initial begin
    int base, g0, b0, d0, len, st;
    #500000;
    $display("FAIL global_timeout: cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int base, g0, b0, d0, len, st;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // 64-byte good frame: eight words, EOP on the last byte, two-cycle release latency
    out_rdy = 1'b1;
    base = wr_log.size();
    send_frame(64, 0, 1'b1);
    wait_drain("drain_t1");
    check("t1_words", wr_log.size() - base, 8);
    check("t1_good_latency", pulse_cyc - drive_cyc, 1);
    if (wr_log.size() - base >= 8) begin
      check("t1_first_data", wr_log[base].data, 64'h0001020304050607);
      check("t1_last_ctrl", wr_log[base + 7].ctrl, 8'h01);
      check("t1_first_wr_latency", wr_cyc[base] - drive_cyc, 2);
      check("t1_no_bubbles", wr_cyc[base + 7] - wr_cyc[base], 7);
    end
    check("t1_byte_cnt", rx_pkt_byte_cnt, 64);

    // 61-byte frame: partial final word, trailing bytes zero
    base = wr_log.size();
    send_frame(61, 0, 1'b1);
    wait_drain("drain_t2");
    check("t2_words", wr_log.size() - base, 8);
    if (wr_log.size() - base >= 8) begin
      check("t2_last_ctrl", wr_log[base + 7].ctrl, 8'h08);
      check("t2_last_data", wr_log[base + 7].data, 64'h38393A3B3C000000);
    end
    check("t2_byte_cnt", rx_pkt_byte_cnt, 61);

    // bad frame discarded, following good frame intact
    base = wr_log.size(); g0 = n_good; b0 = n_bad;
    send_frame(100, 1, 1'b0);
    tick();
    send_frame(64, 0, 1'b0);
    wait_drain("drain_t3");
    check("t3_bad_pulses", n_bad - b0, 1);
    check("t3_good_pulses", n_good - g0, 1);
    check("t3_words", wr_log.size() - base, 8);

    // overflow with reader stalled, then a frame held until out_rdy rises
    out_rdy = 1'b0;
    base = wr_log.size(); g0 = n_good; d0 = n_drop;
    send_frame(200, 0, 1'b0);
    repeat (3) tick();
    check("t4_dropped", n_drop - d0, 1);
    check("t4_pkts_waiting", dut.pkts_waiting, 0);
    send_frame(64, 0, 1'b0);
    repeat (5) tick();
    check("t4_held", wr_log.size() - base, 0);
    out_rdy = 1'b1;
    wait_drain("drain_t4");
    check("t4_words", wr_log.size() - base, 8);
    check("t4_good_pulses", n_good - g0, 1);

    // three back-to-back 60-byte frames with out_rdy toggling
    rdy_rand = 1'b1;
    base = wr_log.size();
    for (int i = 0; i < 3; i++) begin
      wait_room(8);
      send_frame(60, 0, 1'b0);
    end
    wait_drain("drain_t5");
    check("t5_words", wr_log.size() - base, 24);
    check("t5_pkts_waiting", dut.pkts_waiting, 0);
    rdy_rand = 1'b0;
    out_rdy = 1'b1;

    // disabled frame dropped, reset mid-frame loses the frame, next frame normal
    base = wr_log.size(); g0 = n_good; d0 = n_drop;
    rx_queue_en = 1'b0;
    send_frame(50, 0, 1'b0);
    rx_queue_en = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 40; i++) begin
      gmac_rx_data = 8'($urandom);
      gmac_rx_dvld = 1'b1;
      if (i == 20) reset_n = 1'b0;
      if (i == 24) reset_n = 1'b1;
      tick();
    end
    gmac_rx_dvld = 1'b0;
    tick();
    gmac_rx_goodframe = 1'b1;
    tick();
    gmac_rx_goodframe = 1'b0;
    repeat (10) tick();
    check("t6_no_output", wr_log.size() - base, 0);
    check("t6_dropped", n_drop - d0, 1);
    check("t6_no_good", n_good - g0, 0);
    send_frame(64, 0, 1'b0);
    wait_drain("drain_t6");
    check("t6_words", wr_log.size() - base, 8);
    check("t6_good_pulses", n_good - g0, 1);

    // randomized frames against the model
    rdy_rand = 1'b1;
    for (int i = 0; i < 30; i++) begin
      len = $urandom_range(1, 128);
      rx_queue_en = ($urandom_range(0, 9) != 0);
      st = $urandom_range(0, 9);
      st = (st < 7) ? 0 : (st < 9) ? 1 : 2;
      if (st == 2 && (!rx_queue_en || i == 29)) st = 0;
      wait_room((len + 7) / 8);
      send_frame(len, st, 1'b0);
      if (st == 2) tick();
      else repeat ($urandom_range(0, 3)) tick();
    end
    rx_queue_en = 1'b1;
    wait_drain("drain_random");
    rdy_rand = 1'b0;
    out_rdy = 1'b1;
    repeat (10) tick();
    check("final_pkts_waiting", dut.pkts_waiting, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/rx_pkt_buffer.md
# rx_pkt_buffer

Receive-side packet buffer between the Ethernet MAC receive interface and the core datapath; the receive counterpart of the transmit queue. It accepts the MAC's byte stream (one byte per cycle with data-valid and a good/bad frame status), packs bytes into DATA_WIDTH words with per-byte EOP ctrl bits, and stores each frame in an internal buffer. Only frames the MAC marks good are released to the core; bad, overflowing or disabled frames are discarded by rewinding the write pointer. Single clock domain; the core and MAC clocks are identical here.

## Interface
- DATA_WIDTH, 64, core word width (32 or 64)
- CTRL_WIDTH, DATA_WIDTH/8, ctrl bits per word, one per byte
- BUF_ADDR_WIDTH, 9, log2 of buffer depth in words

- clk  in  1  clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- gmac_rx_data  in  8  received byte
- gmac_rx_dvld  in  1  gmac_rx_data valid; contiguous for one frame
- gmac_rx_goodframe  in  1  one-cycle pulse: last frame good
- gmac_rx_badframe  in  1  one-cycle pulse: last frame bad
- out_data  out  DATA_WIDTH  packed word to core
- out_ctrl  out  CTRL_WIDTH  0 on non-final words; one-hot last-byte marker on final word
- out_wr  out  1  out_data/out_ctrl valid this cycle
- out_rdy  in  1  downstream can accept words
- rx_queue_en  in  1  frames starting while low are dropped
- rx_pkt_good  out  1  pulse: frame committed
- rx_pkt_bad  out  1  pulse: frame discarded on badframe
- rx_pkt_dropped  out  1  pulse: frame discarded on overflow or disable
- rx_pkt_byte_cnt  out  12  byte length of last committed frame

## Operation
- Byte order: byte k of a word (k=0 first on wire) occupies out_data[DATA_WIDTH-1-8k -: 8]; its EOP flag is ctrl bit CTRL_WIDTH-1-k. Unused trailing bytes of the final word are zero.
- Buffer: 2**BUF_ADDR_WIDTH entries of DATA_WIDTH+CTRL_WIDTH bits; pointers BUF_ADDR_WIDTH+1 bits wide (wrap bit). Pointers: wr_ptr (speculative), commit_ptr, rd_ptr. Full when wr_ptr-rd_ptr == 2**BUF_ADDR_WIDTH.
- Packing: byte index counter, log2(CTRL_WIDTH) bits, clears at frame start. A completed word is held pending and written when the next byte arrives (ctrl=0) or when dvld falls (ctrl marks the last byte). A partial final word is written when dvld falls.
- Write FSM:
  - WR_IDLE: dvld rises -> WR_PKT if rx_queue_en=1 and buffer not full, else WR_DROP.
  - WR_PKT: pack/write; dvld falls -> WR_STATUS; a write that would exceed full -> WR_DROP.
  - WR_STATUS: goodframe -> commit_ptr<=wr_ptr, pkts_waiting+1, rx_pkt_good, latch byte count -> WR_IDLE. badframe -> wr_ptr<=commit_ptr, rx_pkt_bad -> WR_IDLE. dvld rises before either -> treat as bad (rewind, rx_pkt_bad), start new frame as from WR_IDLE.
  - WR_DROP: wr_ptr<=commit_ptr; ignore bytes; after dvld falls, the next good/bad pulse -> rx_pkt_dropped (once per frame) -> WR_IDLE. No rx_pkt_good/bad for dropped frames.
- Byte counter saturates at 4095.
- Read FSM: RD_IDLE -> RD_PKT when pkts_waiting != 0. RD_PKT: each cycle out_rdy=1, read entry at rd_ptr, rd_ptr+1. On issuing the word with nonzero ctrl: pkts_waiting-1, -> RD_IDLE. Reader never passes commit_ptr.
- pkts_waiting: BUF_ADDR_WIDTH+1 bits; simultaneous increment and decrement leave it unchanged.

## Timing
- Reset (async, reset_n low): out_data=0, out_ctrl=0, out_wr=0, all pulses 0, rx_pkt_byte_cnt=0, all pointers and pkts_waiting 0, both FSMs idle. An in-progress frame is lost; after release, bytes are ignored until the next dvld rising edge.
- out_rdy sampled high in cycle N -> out_wr=1 with that word in cycle N+1 (registered read). out_rdy low in N -> out_wr=0 in N+1. Downstream must deassert out_rdy with at least one word of slack.
- goodframe in cycle N -> pkts_waiting nonzero at N+1 -> first out_wr no earlier than N+2 (exactly N+2 if out_rdy held high and reader idle).
- Status pulses are single-cycle and registered, asserted the cycle after the causing event.
- Sustained throughput: one word per cycle out, one byte per cycle in; no bubbles while out_rdy=1 within a packet.

## Test plan
- 64-byte good frame, out_rdy=1, DATA_WIDTH=64 -> 8 out_wr words in wire order, words 0-6 ctrl=0x00, word 7 ctrl=0x01; rx_pkt_good one pulse; rx_pkt_byte_cnt=64.
- 61-byte good frame -> 8 words; final ctrl=0x08, final word bytes 5-7 zero; rx_pkt_byte_cnt=61.
- 100-byte frame ending with badframe, then 64-byte good frame -> rx_pkt_bad one pulse, no words from the first frame, second frame delivered intact.
- BUF_ADDR_WIDTH=4, out_rdy=0, 200-byte frame -> rx_pkt_dropped one pulse, pkts_waiting=0; following 64-byte frame committed and delivered once out_rdy=1.
- Three back-to-back 60-byte frames with out_rdy toggled pseudo-randomly -> all 24 words in order, out_wr never one cycle after out_rdy low, pkts_waiting returns to 0.
- rx_queue_en=0 for one frame, reset_n pulsed mid-way through the next -> one rx_pkt_dropped, no output, all outputs 0 during reset; a subsequent good frame is delivered normally.
